vrased_rst_seq: RTL and testbench

- Receiving end of the violation-reset path. Takes the per-monitor violation strobes (X_stack, AC, atomicity, dma_AC, dma_detect, dma_X_stack) and turns them into a clean, minimum-width CPU reset.
- Confirms the restart by watching for the first fetch at RESET_HANDLER, and retries if that fetch does not arrive.
- Keeps a sticky cause vector and a saturating violation counter for post-mortem.
- Sits between the monitor bank and the openMSP430 PUC input.

---
 rtl/vrased_rst_seq_if.sv | 24 ++
 rtl/vrased_rst_seq.sv | 131 +++++++++++++
 tb/tb_vrased_rst_seq.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vrased_rst_seq_if.sv
// Violation-reset sequencer bus: monitor-bank strobes and PC in, CPU reset and post-mortem log out.
interface vrased_rst_seq_if #(
    parameter int unsigned NUM_SRC = 6,
    parameter int unsigned CNT_W   = 8
);
    logic [NUM_SRC-1:0] viol;
    logic [15:0]        pc;
    logic               cause_clr;
    logic               puc_rst;
    logic               busy;
    logic [NUM_SRC-1:0] cause;
    logic [CNT_W-1:0]   viol_cnt;
    logic               fetch_fail;

    modport master (
        output viol, pc, cause_clr,
        input  puc_rst, busy, cause, viol_cnt, fetch_fail
    );

    modport slave (
        input  viol, pc, cause_clr,
        output puc_rst, busy, cause, viol_cnt, fetch_fail
    );
endinterface

// File: rtl/vrased_rst_seq.sv
// Turns monitor violation strobes into a fixed-width CPU reset, confirms restart at RESET_HANDLER.
// Optional post-mortem log (cause, viol_cnt, fetch_fail) enabled by VRASED_RST_CAUSE_LOG_EN.
module vrased_rst_seq #(
    parameter int unsigned NUM_SRC       = 6,
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter int unsigned FETCH_TIMEOUT = 64,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    vrased_rst_seq_if.slave  bus
);

    localparam int unsigned HOLD_W  = (HOLD_CYCLES > 2)   ? $clog2(HOLD_CYCLES)   : 1;
    localparam int unsigned FETCH_W = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_HOLD       = 2'd1,
        ST_WAIT_FETCH = 2'd2
    } state_e;

    state_e               state_q;
    logic                 puc_rst_q;
    logic [HOLD_W-1:0]    hold_ctr_q;
    logic [FETCH_W-1:0]   fetch_ctr_q;

    logic viol_any;
    logic pc_hit;

    assign viol_any = |bus.viol;
    assign pc_hit   = (bus.pc == RESET_HANDLER);

    // Sequencer: hold_ctr counts down HOLD_CYCLES-1..0, so puc_rst spans exactly HOLD_CYCLES cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            puc_rst_q   <= 1'b0;
            hold_ctr_q  <= '0;
            fetch_ctr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (viol_any) begin
                        state_q    <= ST_HOLD;
                        puc_rst_q  <= 1'b1;
                        hold_ctr_q <= HOLD_W'(HOLD_CYCLES - 1);
                    end
                end
                ST_HOLD: begin
                    if (hold_ctr_q == '0) begin
                        state_q     <= ST_WAIT_FETCH;
                        puc_rst_q   <= 1'b0;
                        fetch_ctr_q <= FETCH_W'(FETCH_TIMEOUT - 1);
                    end else begin
                        hold_ctr_q <= hold_ctr_q - HOLD_W'(1);
                    end
                end
                ST_WAIT_FETCH: begin
                    // A fresh violation beats a PC match; a timeout retries the reset.
                    if (viol_any) begin
                        state_q    <= ST_HOLD;
                        puc_rst_q  <= 1'b1;
                        hold_ctr_q <= HOLD_W'(HOLD_CYCLES - 1);
                    end else if (pc_hit) begin
                        state_q <= ST_IDLE;
                    end else if (fetch_ctr_q == '0) begin
                        state_q    <= ST_HOLD;
                        puc_rst_q  <= 1'b1;
                        hold_ctr_q <= HOLD_W'(HOLD_CYCLES - 1);
                    end else begin
                        fetch_ctr_q <= fetch_ctr_q - FETCH_W'(1);
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    puc_rst_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.puc_rst = puc_rst_q;
    assign bus.busy    = (state_q != ST_IDLE);

`ifdef VRASED_RST_CAUSE_LOG_EN
    logic [NUM_SRC-1:0] cause_q;
    logic [CNT_W-1:0]   viol_cnt_q;
    logic               fetch_fail_q;

    logic episode_c;
    logic timeout_c;
    logic clr_c;

    assign episode_c = viol_any && (state_q != ST_HOLD);
    assign timeout_c = (state_q == ST_WAIT_FETCH) && !viol_any && !pc_hit && (fetch_ctr_q == '0);
    assign clr_c     = (state_q == ST_IDLE) && bus.cause_clr;

    // Post-mortem log; a clear in IDLE still captures any violation arriving in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_q      <= '0;
            viol_cnt_q   <= '0;
            fetch_fail_q <= 1'b0;
        end else begin
            cause_q <= clr_c ? bus.viol : (cause_q | bus.viol);
            if (clr_c) begin
                fetch_fail_q <= 1'b0;
            end else if (timeout_c) begin
                fetch_fail_q <= 1'b1;
            end
            if (episode_c && (viol_cnt_q != {CNT_W{1'b1}})) begin
                viol_cnt_q <= viol_cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.cause      = cause_q;
    assign bus.viol_cnt   = viol_cnt_q;
    assign bus.fetch_fail = fetch_fail_q;
`else
    logic unused_cause_clr;
    assign unused_cause_clr = bus.cause_clr;

    assign bus.cause      = '0;
    assign bus.viol_cnt   = '0;
    assign bus.fetch_fail = 1'b0;
`endif

endmodule

// File: tb/tb_vrased_rst_seq.sv
// Bench for vrased_rst_seq: timestamp-based episode model checked every cycle, plus directed literal checks.
module tb_vrased_rst_seq;

    localparam int unsigned NUM_SRC = 6;
    localparam int unsigned CNT_W   = 8;
    localparam int          HOLD    = 16;
    localparam int          TMO     = 64;
    localparam logic [15:0] RH      = 16'h0000;
    localparam logic [15:0] PC_RUN  = 16'hA010;
`ifdef VRASED_RST_CAUSE_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vrased_rst_seq_if #(.NUM_SRC(NUM_SRC), .CNT_W(CNT_W)) bus ();

    vrased_rst_seq #(
        .NUM_SRC(NUM_SRC), .HOLD_CYCLES(HOLD), .RESET_HANDLER(RH),
        .FETCH_TIMEOUT(TMO), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 reset held, 2 awaiting fetch; durations from edge timestamps.
    int                 m_mode  = 0;
    int                 m_t     = 0;
    int                 m_t0    = 0;
    int                 m_cnt   = 0;
    logic [NUM_SRC-1:0] m_cause = '0;
    logic               m_ff    = 1'b0;

    function automatic int sat_inc(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode <= 0; m_t <= 0; m_t0 <= 0; m_cnt <= 0; m_cause <= '0; m_ff <= 1'b0;
        end else begin
            m_t <= m_t + 1;
            case (m_mode)
                0: begin
                    if (bus.viol != '0) begin
                        m_cause <= (bus.cause_clr ? '0 : m_cause) | bus.viol;
                        if (bus.cause_clr) m_ff <= 1'b0;
                        m_cnt  <= sat_inc(m_cnt);
                        m_mode <= 1;
                        m_t0   <= m_t + 1;
                    end else if (bus.cause_clr) begin
                        m_cause <= '0;
                        m_ff    <= 1'b0;
                    end
                end
                1: begin
                    m_cause <= m_cause | bus.viol;
                    if ((m_t + 1) - m_t0 == HOLD) begin
                        m_mode <= 2;
                        m_t0   <= m_t + 1;
                    end
                end
                default: begin
                    if (bus.viol != '0) begin
                        m_cause <= m_cause | bus.viol;
                        m_cnt   <= sat_inc(m_cnt);
                        m_mode  <= 1;
                        m_t0    <= m_t + 1;
                    end else if (bus.pc == RH) begin
                        m_mode <= 0;
                    end else if ((m_t + 1) - m_t0 == TMO) begin
                        m_ff   <= 1'b1;
                        m_mode <= 1;
                        m_t0   <= m_t + 1;
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("puc_rst",    32'(bus.puc_rst),    32'(m_mode == 1));
            chk("busy",       32'(bus.busy),       32'(m_mode != 0));
            chk("cause",      32'(bus.cause),      LOG_EN ? 32'(m_cause) : 32'd0);
            chk("viol_cnt",   32'(bus.viol_cnt),   LOG_EN ? 32'(m_cnt)   : 32'd0);
            chk("fetch_fail", 32'(bus.fetch_fail), LOG_EN ? 32'(m_ff)    : 32'd0);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic pulse(input logic [NUM_SRC-1:0] v);
        bus.viol = v;
        tick();
        bus.viol = '0;
    endtask

    // Counts high cycles of puc_rst from the current one; optionally injects viol/cause_clr at index at_i.
    task automatic run_hold(input logic [NUM_SRC-1:0] v_at, input logic clr_at, input int at_i,
                            output int w);
        w = 0;
        while (bus.puc_rst === 1'b1 && w < 200) begin
            bus.viol      = (w == at_i) ? v_at : '0;
            bus.cause_clr = (w == at_i) ? clr_at : 1'b0;
            w++;
            tick();
        end
        bus.viol      = '0;
        bus.cause_clr = 1'b0;
    endtask

    task automatic go_idle();
        for (int i = 0; i < 200 && bus.busy === 1'b1; i++) begin
            bus.pc = (bus.puc_rst === 1'b1) ? PC_RUN : RH;
            tick();
        end
        bus.pc = PC_RUN;
        chk("go_idle_busy", 32'(bus.busy), 32'd0);
    endtask

    function automatic logic [31:0] lg(input logic [31:0] v);
        return LOG_EN ? v : 32'd0;
    endfunction

    int w;
    int lo;

    initial begin
        bus.viol      = '0;
        bus.pc        = PC_RUN;
        bus.cause_clr = 1'b0;
        reset         = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        chk("rst_puc",   32'(bus.puc_rst),    32'd0);
        chk("rst_busy",  32'(bus.busy),       32'd0);
        chk("rst_cause", 32'(bus.cause),      32'd0);
        chk("rst_cnt",   32'(bus.viol_cnt),   32'd0);
        chk("rst_ff",    32'(bus.fetch_fail), 32'd0);
        tick();

        // Single atomicity strobe, fetch confirmed on the 3rd post-release cycle.
        pulse(6'b000100);
        run_hold('0, 1'b0, -1, w);
        chk("s1_width", 32'(w), 32'd16);
        tick(); tick();
        bus.pc = RH;
        tick();
        bus.pc = PC_RUN;
        chk("s1_busy",  32'(bus.busy),     32'd0);
        chk("s1_cause", 32'(bus.cause),    lg(32'h04));
        chk("s1_cnt",   32'(bus.viol_cnt), lg(32'd1));

        // Clear in IDLE, then X_stack with dma_X_stack arriving mid-hold.
        bus.cause_clr = 1'b1;
        tick();
        bus.cause_clr = 1'b0;
        chk("clr_idle_cause", 32'(bus.cause), 32'd0);
        pulse(6'b000001);
        run_hold(6'b100000, 1'b0, 2, w);
        chk("s2_width", 32'(w), 32'd16);
        chk("s2_cause", 32'(bus.cause),    lg(32'h21));
        chk("s2_cnt",   32'(bus.viol_cnt), lg(32'd2));

        // No fetch: 64 cycles of waiting, then a retry pulse without counting.
        lo = 0;
        while (bus.puc_rst !== 1'b1 && lo < 200) begin
            lo++;
            tick();
        end
        chk("s3_wait", 32'(lo), 32'd64);
        chk("s3_ff",   32'(bus.fetch_fail), lg(32'd1));
        chk("s3_cnt",  32'(bus.viol_cnt),   lg(32'd2));
        run_hold('0, 1'b0, -1, w);
        chk("s3_width", 32'(w), 32'd16);

        // Violation and PC match together: violation wins; cause_clr in HOLD ignored.
        tick();
        bus.viol = 6'b010000;
        bus.pc   = RH;
        tick();
        bus.viol = '0;
        bus.pc   = PC_RUN;
        chk("s4_puc",  32'(bus.puc_rst),  32'd1);
        chk("s4_cnt",  32'(bus.viol_cnt), lg(32'd3));
        run_hold('0, 1'b1, 3, w);
        chk("s4_width", 32'(w), 32'd16);
        chk("s4_cause", 32'(bus.cause),      lg(32'h31));
        chk("s4_ff",    32'(bus.fetch_fail), lg(32'd1));
        go_idle();

        // Clear and new violation in the same IDLE cycle.
        bus.cause_clr = 1'b1;
        bus.viol      = 6'b000010;
        tick();
        bus.cause_clr = 1'b0;
        bus.viol      = '0;
        chk("s5_cause", 32'(bus.cause),      lg(32'h02));
        chk("s5_ff",    32'(bus.fetch_fail), 32'd0);
        chk("s5_cnt",   32'(bus.viol_cnt),   lg(32'd4));
        go_idle();

        // Continuous violation: repeated holds separated by one waiting cycle.
        bus.viol = 6'b001000;
        repeat (60) tick();
        bus.viol = '0;
        go_idle();

        // Saturation across 300 episodes.
        for (int k = 0; k < 300; k++) begin
            pulse(6'b000001);
            go_idle();
        end
        chk("sat_cnt", 32'(bus.viol_cnt), lg(32'hFF));
        bus.cause_clr = 1'b1;
        tick();
        bus.cause_clr = 1'b0;
        chk("clr2_cause", 32'(bus.cause),      32'd0);
        chk("clr2_ff",    32'(bus.fetch_fail), 32'd0);

        // Asynchronous reset on the 5th hold cycle.
        pulse(6'b000100);
        repeat (4) tick();
        chk("pre_rst_puc", 32'(bus.puc_rst), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("arst_puc",   32'(bus.puc_rst),    32'd0);
        chk("arst_busy",  32'(bus.busy),       32'd0);
        chk("arst_cause", 32'(bus.cause),      32'd0);
        chk("arst_cnt",   32'(bus.viol_cnt),   32'd0);
        chk("arst_ff",    32'(bus.fetch_fail), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // First scenario again after reset.
        pulse(6'b000100);
        run_hold('0, 1'b0, -1, w);
        chk("s6_width", 32'(w), 32'd16);
        go_idle();
        chk("s6_cause", 32'(bus.cause),    lg(32'h04));
        chk("s6_cnt",   32'(bus.viol_cnt), lg(32'd1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
